// File: rtl/sdram_rw_arbiter_pkg.sv
// Shared definitions for the two-client SDRAM read/write arbiter:
// FSM state encodings, burst-length limits and the length legality check.
package sdram_rw_arbiter_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_XFER  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    localparam logic [9:0] MAX_WR_BURST = 10'd512;
    localparam logic [9:0] MAX_RD_BURST = 10'd256;

    // A burst is legal when non-empty and within the controller's limit for its direction.
    function automatic logic burst_len_ok(input logic we, input logic [9:0] len);
        if (len == 10'd0) begin
            return 1'b0;
        end
        return we ? (len <= MAX_WR_BURST) : (len <= MAX_RD_BURST);
    endfunction

endpackage

// File: rtl/sdram_rw_arbiter_rr2.sv
// Two-way round-robin picker. The pick is combinational from the current
// requests; the memory of who was served last is a register updated when
// the arbiter retires a transaction.
module sdram_rw_arbiter_rr2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    input  logic       adv_idx_i,
    output logic [1:0] pick_o,
    output logic       last_gnt_o
);

    logic last_gnt_q;

    // Remember the client retired most recently; reset favours client 0 on the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt_q <= 1'b1;
        end else if (advance_i) begin
            last_gnt_q <= adv_idx_i;
        end
    end

    // Sole requester wins; on a tie the client not served last wins.
    always_comb begin
        pick_o = 2'b00;
        case (req_i)
            2'b01:   pick_o = 2'b01;
            2'b10:   pick_o = 2'b10;
            2'b11:   pick_o = last_gnt_q ? 2'b01 : 2'b10;
            default: pick_o = 2'b00;
        endcase
    end

    assign last_gnt_o = last_gnt_q;

endmodule

// File: rtl/sdram_rw_arbiter.sv
// Shares one SDRAM controller port between two burst clients. One transaction
// at a time: request issue, watchdog on the first ack, word counting, and a
// one-cycle done/err pulse to the owning client.
module sdram_rw_arbiter
    import sdram_rw_arbiter_pkg::*;
#(
    parameter int          ADDR_W  = 24,
    parameter int          DATA_W  = 16,
    parameter logic [11:0] TIMEOUT = 12'd4000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c0_req,
    input  logic              c0_we,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic [9:0]        c0_len,
    input  logic [DATA_W-1:0] c0_wdata,
    output logic              c0_gnt,
    output logic              c0_wr_ack,
    output logic              c0_rd_valid,
    output logic              c0_done,
    output logic              c0_err,
    input  logic              c1_req,
    input  logic              c1_we,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [9:0]        c1_len,
    input  logic [DATA_W-1:0] c1_wdata,
    output logic              c1_gnt,
    output logic              c1_wr_ack,
    output logic              c1_rd_valid,
    output logic              c1_done,
    output logic              c1_err,
    input  logic              sdram_init_done,
    output logic              sdram_wr_req,
    output logic              sdram_rd_req,
    input  logic              sdram_wr_ack,
    input  logic              sdram_rd_ack,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [9:0]        sdram_wr_burst,
    output logic [9:0]        sdram_rd_burst,
    output logic [DATA_W-1:0] sdram_wdata,
    input  logic [DATA_W-1:0] sdram_rdata
);

    localparam logic [11:0] WD_LAST = TIMEOUT - 12'd1;

    logic [1:0]        req_v;
    logic [1:0]        we_v;
    logic [ADDR_W-1:0] addr_v  [2];
    logic [9:0]        len_v   [2];
    logic [DATA_W-1:0] wdata_v [2];
    logic [1:0]        gnt_v, wr_ack_v, rd_valid_v, done_v, err_v;

    logic [2:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [9:0]        len_q, len_d;
    logic [9:0]        cnt_q, cnt_d;
    logic [11:0]       wd_q, wd_d;

    logic [1:0]        pick;
    logic              sel_idx;
    logic              active;
    logic              retire;
    logic              match_ack;
    logic              rr_last_gnt_unused;
    logic              unused_rdata;

    assign req_v      = {c1_req, c0_req};
    assign we_v       = {c1_we, c0_we};
    assign addr_v[0]  = c0_addr;
    assign addr_v[1]  = c1_addr;
    assign len_v[0]   = c0_len;
    assign len_v[1]   = c1_len;
    assign wdata_v[0] = c0_wdata;
    assign wdata_v[1] = c1_wdata;

    // Read data goes to the clients by direct wiring; the arbiter only qualifies it.
    assign unused_rdata = ^sdram_rdata;

    assign active    = (state_q == S_ISSUE) || (state_q == S_XFER);
    assign retire    = (state_q == S_DONE) || (state_q == S_ERR);
    assign match_ack = we_q ? sdram_wr_ack : sdram_rd_ack;
    assign sel_idx   = pick[1];

    sdram_rw_arbiter_rr2 u_rr2 (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_v),
        .advance_i  (retire),
        .adv_idx_i  (owner_q),
        .pick_o     (pick),
        .last_gnt_o (rr_last_gnt_unused)
    );

    // Transaction sequencing: pick, issue, count words, retire.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        wd_d    = wd_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = 10'd0;
                wd_d  = 12'd0;
                if (sdram_init_done && (|pick)) begin
                    owner_d = sel_idx;
                    we_d    = we_v[sel_idx];
                    addr_d  = addr_v[sel_idx];
                    len_d   = len_v[sel_idx];
                    state_d = burst_len_ok(we_v[sel_idx], len_v[sel_idx]) ? S_ISSUE : S_ERR;
                end
            end
            S_ISSUE: begin
                if (match_ack) begin
                    cnt_d   = cnt_q + 10'd1;
                    state_d = S_XFER;
                end else if (wd_q >= WD_LAST) begin
                    state_d = S_ERR;
                end else if (wd_q != 12'hFFF) begin
                    wd_d = wd_q + 12'd1;
                end
            end
            S_XFER: begin
                if (match_ack) begin
                    cnt_d = cnt_q + 10'd1;
                end else begin
                    state_d = (cnt_q == len_q) ? S_DONE : S_ERR;
                end
            end
            S_DONE, S_ERR: state_d = S_IDLE;
            default:       state_d = S_IDLE;
        endcase
    end

    // State and transaction registers; reset abandons any burst in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            len_q   <= 10'd0;
            cnt_q   <= 10'd0;
            wd_q    <= 12'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
        end
    end

    assign sdram_wr_req   = (state_q == S_ISSUE) && we_q;
    assign sdram_rd_req   = (state_q == S_ISSUE) && !we_q;
    assign sdram_addr     = addr_q;
    assign sdram_wr_burst = we_q ? len_q : 10'd0;
    assign sdram_rd_burst = we_q ? 10'd0 : len_q;
    assign sdram_wdata    = active ? wdata_v[owner_q] : '0;

    // Per-client steering of grant, strobes and completion.
    for (genvar gi = 0; gi < 2; gi++) begin : g_client
        assign gnt_v[gi]      = active && (owner_q == 1'(gi));
        assign wr_ack_v[gi]   = sdram_wr_ack && gnt_v[gi] && we_q;
        assign rd_valid_v[gi] = sdram_rd_ack && gnt_v[gi] && !we_q;
        assign done_v[gi]     = retire && (owner_q == 1'(gi));
        assign err_v[gi]      = (state_q == S_ERR) && (owner_q == 1'(gi));
    end

    assign c0_gnt      = gnt_v[0];
    assign c1_gnt      = gnt_v[1];
    assign c0_wr_ack   = wr_ack_v[0];
    assign c1_wr_ack   = wr_ack_v[1];
    assign c0_rd_valid = rd_valid_v[0];
    assign c1_rd_valid = rd_valid_v[1];
    assign c0_done     = done_v[0];
    assign c1_done     = done_v[1];
    assign c0_err      = err_v[0];
    assign c1_err      = err_v[1];

endmodule

// File: doc/sdram_rw_arbiter.md
# sdram_rw_arbiter

Two-client arbiter that shares the single SDRAM state-control port between independent requesters (e.g. a video-capture writer and a display reader). It accepts per-client burst transactions, grants one at a time in round-robin order, and drives the controller's req/ack/burst/address inputs. It steers write data in and read-valid strobes back, and signals per-transaction completion or error. It sits between the client FIFOs and the SDRAM controller.

## Interface
- ADDR_W, 24, SDRAM word address width (bank+row+column)
- DATA_W, 16, SDRAM data width
- TIMEOUT, 12'd4000, cycles allowed from request issue to first ack before abort
- clk  in  1  system clock (100 MHz domain of SDRAM controller)
- rst  in  1  asynchronous, active-high reset
- cN_req  in  1  client N (N=0,1) transaction request, held until cN_done
- cN_we  in  1  1 = write, 0 = read; stable while cN_req
- cN_addr  in  ADDR_W  start address; stable while cN_req
- cN_len  in  10  burst length in words; stable while cN_req
- cN_wdata  in  DATA_W  write word; must be valid while cN_wr_ack
- cN_gnt  out  1  client N owns the SDRAM port
- cN_wr_ack  out  1  write word consumed this cycle
- cN_rd_valid  out  1  sdram_rdata valid for client N this cycle
- cN_done  out  1  one-cycle completion pulse
- cN_err  out  1  qualifies cN_done: transaction rejected or aborted
- sdram_init_done  in  1  controller initialisation complete
- sdram_wr_req / sdram_rd_req  out  1  controller requests
- sdram_wr_ack / sdram_rd_ack  in  1  controller per-word acks
- sdram_addr  out  ADDR_W  transaction address
- sdram_wr_burst / sdram_rd_burst  out  10  burst lengths
- sdram_wdata  out  DATA_W  muxed write data
- sdram_rdata  in  DATA_W  read data (broadcast to clients)

## Operation
- States: IDLE, ISSUE, XFER, DONE, ERR.
- IDLE: no grant while sdram_init_done=0. Otherwise, if any cN_req, pick the winner: a single requester wins; if both request, the client not granted last wins. last_gnt resets to 1, so client 0 wins the first tie.
- Length check in IDLE: len=0, write len>512, or read len>256 -> ERR with no SDRAM request issued.
- Valid request -> ISSUE. Assert cN_gnt and latch addr/len/we into registers. Drive sdram_addr and the relevant burst output from those registers. Assert sdram_wr_req or sdram_rd_req per we.
- ISSUE: hold the request until the first matching ack is seen, then drop it on the next edge -> XFER. A watchdog counts from ISSUE entry; reaching TIMEOUT with no ack -> ERR.
- XFER: word counter increments on each matching ack. When ack is low after having been high -> DONE.
  - Count == len: success.
  - Count != len: ERR.
- DONE/ERR: one-cycle cN_done (cN_err=1 in ERR). Drop gnt, update last_gnt -> IDLE.
- Data steering (combinational, gated by state ISSUE/XFER):
  - sdram_wdata = granted client's wdata.
  - cN_wr_ack = sdram_wr_ack & gnt & we.
  - cN_rd_valid = sdram_rd_ack & gnt & ~we.
- A client dropping cN_req mid-transaction is ignored; the burst completes.
- A new request from the same client may be presented the cycle after cN_done.
- Reset at any point: state IDLE, all outputs 0, counters 0, last_gnt=1. An in-flight controller burst is abandoned.

## Timing
- cN_req sampled at edge t -> cN_gnt and sdram_*_req high from t+1 (registered).
- Request drops the cycle after the first ack is sampled high.
- cN_done is high the cycle after the ack falling edge is sampled.
- Minimum IDLE gap between transactions is 1 cycle.
- Back-to-back alternation under continuous contention: 0,1,0,1.
- Error on bad length: cN_done+cN_err at t+1, no grant.
- Word counter is 10 bits, sufficient for 512. The watchdog is 12 bits and saturates.

## Structure
- The shared header sdram_arb_param.v holds state encodings (S_IDLE..S_ERR) and the constants MAX_WR_BURST=512 and MAX_RD_BURST=256.
- One sub-module, sdram_arb_rr2: registered two-way round-robin picker (req[1:0], advance strobe -> one-hot grant, last_gnt).
- The rest (FSM, counters, muxes) lives in the top.

## Test plan
- Single write: c0 write, addr 0x000100, len 8; controller model acks 8 cycles -> 8 c0_wr_ack, c0_done, c0_err=0, sdram_wr_burst=8.
- Contention: c0 and c1 both request reads of len 4 in the same cycle, repeated 4 times -> grant order 0,1,0,1, with no overlap of gnt.
- Bad length: c1 read len 300 -> c1_done+c1_err one cycle later, sdram_rd_req never asserted. Also c0 len 0 -> same error behaviour.
- Timeout: controller never acks; after TIMEOUT=4000 cycles -> c0_err pulse, request dropped, next requester served.
- Short burst: read len 8 but the model gives 6 acks -> c0_done with c0_err=1.
- Init gating and reset: requests while sdram_init_done=0 get no grant. rst asserted mid-XFER -> all outputs 0 immediately; after release, c0 wins the first tie.
